// File: rtl/lfsr_regfile.sv
// ---------------------------------------------------------------------------
// LfsrRegfile - two-bank operand register file feeding the ALU.
//
// Bank A drives ALU operand a and bank B drives operand b. Index 0 of both
// banks is a hard-wired zero. Bank A index 1 is a Galois LFSR that steps
// each time it is read with the read strobe raised. Writes to A[1] reseed
// the LFSR, and a written zero is replaced by the seed so the LFSR cannot
// lock up.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_wr_en      write enable
//   i_wr_addr    {bank, index}; MSB = 0 selects bank A, 1 selects bank B
//   i_wr_data    write data
//   i_rd_addr_a  bank A read index
//   i_rd_en_a    bank A read strobe; only used to step the LFSR
//   i_rd_addr_b  bank B read index
//   o_data_out_a bank A read data (combinational)
//   o_data_out_b bank B read data (combinational)
//   o_lfsr_wrap  registered pulse when an LFSR step lands back on the seed
// ---------------------------------------------------------------------------
module lfsr_regfile #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   LFSR_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0]   LFSR_SEED = 8'h01,
    parameter int                 BYPASS    = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [$clog2(DEPTH):0]      i_wr_addr,
    input  logic [WIDTH-1:0]            i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]    i_rd_addr_a,
    input  logic                        i_rd_en_a,
    input  logic [$clog2(DEPTH)-1:0]    i_rd_addr_b,
    output logic [WIDTH-1:0]            o_data_out_a,
    output logic [WIDTH-1:0]            o_data_out_b,
    output logic                        o_lfsr_wrap
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_IDX = '0;
    localparam logic [AW-1:0] LFSR_IDX = AW'(1);

    logic [WIDTH-1:0] r_bankA [0:DEPTH-1];
    logic [WIDTH-1:0] r_bankB [0:DEPTH-1];
    logic [WIDTH-1:0] r_lfsr;
    logic             r_lfsrWrap;

    logic             w_wrBankB;
    logic [AW-1:0]    w_wrIdx;
    logic             w_lfsrWrite;
    logic             w_lfsrAdvance;
    logic [WIDTH-1:0] w_lfsrNext;
    logic [WIDTH-1:0] w_lfsrLoad;
    logic [WIDTH-1:0] w_dataA;
    logic [WIDTH-1:0] w_dataB;

    // Split the write address into bank select and index, and decide
    // whether this cycle touches the LFSR through a write or a strobed read.
    always_comb begin
        w_wrBankB     = i_wr_addr[AW];
        w_wrIdx       = i_wr_addr[AW-1:0];
        w_lfsrWrite   = i_wr_en && !w_wrBankB && (w_wrIdx == LFSR_IDX);
        w_lfsrAdvance = i_rd_en_a && (i_rd_addr_a == LFSR_IDX);
    end

    // Galois step: shift right and fold the taps in when a one falls out.
    // A written zero is swapped for the seed, since zero is the one state
    // the LFSR could never leave.
    always_comb begin
        w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
        w_lfsrLoad = (i_wr_data == '0) ? LFSR_SEED : i_wr_data;
    end

    // Register storage and LFSR state. Index 0 of both banks and A[1] are
    // never written into the arrays; their read values come from the read
    // muxes instead. A write to the LFSR beats a simultaneous step, and in
    // that case no wrap pulse is produced.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bankA[i] <= '0;
                r_bankB[i] <= '0;
            end
            r_lfsr     <= LFSR_SEED;
            r_lfsrWrap <= 1'b0;
        end else begin
            r_lfsrWrap <= 1'b0;
            if (i_wr_en && (w_wrIdx != ZERO_IDX)) begin
                if (w_wrBankB) begin
                    r_bankB[w_wrIdx] <= i_wr_data;
                end else if (w_wrIdx != LFSR_IDX) begin
                    r_bankA[w_wrIdx] <= i_wr_data;
                end
            end
            if (w_lfsrWrite) begin
                r_lfsr <= w_lfsrLoad;
            end else if (w_lfsrAdvance) begin
                r_lfsr     <= w_lfsrNext;
                r_lfsrWrap <= (w_lfsrNext == LFSR_SEED);
            end
        end
    end

    // Bank A read mux. The zero register and the LFSR always show their
    // own state; forwarding of a same-cycle write only covers ordinary
    // registers.
    always_comb begin
        w_dataA = r_bankA[i_rd_addr_a];
        if (i_rd_addr_a == ZERO_IDX) begin
            w_dataA = '0;
        end else if (i_rd_addr_a == LFSR_IDX) begin
            w_dataA = r_lfsr;
        end else if ((BYPASS != 0) && i_wr_en && !w_wrBankB && (w_wrIdx == i_rd_addr_a)) begin
            w_dataA = i_wr_data;
        end
    end

    // Bank B read mux, same rules without the LFSR slot.
    always_comb begin
        w_dataB = r_bankB[i_rd_addr_b];
        if (i_rd_addr_b == ZERO_IDX) begin
            w_dataB = '0;
        end else if ((BYPASS != 0) && i_wr_en && w_wrBankB && (w_wrIdx == i_rd_addr_b)) begin
            w_dataB = i_wr_data;
        end
    end

    assign o_data_out_a = w_dataA;
    assign o_data_out_b = w_dataB;
    assign o_lfsr_wrap  = r_lfsrWrap;

endmodule
